// File: rtl/srambank_pkg.sv
// srambank_pkg: shared constants and helpers for the srambank_multi bank group.
// The derived widths describe the default build; the top re-derives them
// from its own parameters through clog2().
package srambank_pkg;

   localparam int WIDTH_DEF     = 74;
   localparam int DEPTH_DEF     = 64;
   localparam int NBANKS_DEF    = 4;
   localparam int MASK_GRAN_DEF = 37;

   // ceil(log2(n)); clog2(1) = 0 so a single bank needs no select bits
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   localparam int ROW_W  = clog2(DEPTH_DEF);
   localparam int BANK_W = clog2(NBANKS_DEF);
   localparam int ADDR_W = BANK_W + ROW_W;
   localparam int NSEG   = WIDTH_DEF / MASK_GRAN_DEF;

   localparam int ERR_COLL = 0;
   localparam int ERR_OOR  = 1;

endpackage

// File: rtl/srambank_array.sv
// srambank_array: one DEPTH x WIDTH bank with per-segment write mask and a
// registered read port. The caller guarantees row < DEPTH on any access.
module srambank_array
   import srambank_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int MASK_GRAN = MASK_GRAN_DEF,
   parameter int RW        = clog2(DEPTH),
   parameter int NS        = WIDTH / MASK_GRAN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic             re,
   input  logic [RW-1:0]    row,
   input  logic [WIDTH-1:0] wd,
   input  logic [NS-1:0]    wmask,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // masked write; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (we) begin
         for (int s = 0; s < NS; s++) begin
            if (wmask[s]) mem[row][s*MASK_GRAN +: MASK_GRAN] <= wd[s*MASK_GRAN +: MASK_GRAN];
         end
      end
   end

   // read register only updates on an accepted read, so it holds the last result
   always_ff @(posedge clk or posedge reset) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[row];
   end

endmodule

// File: rtl/srambank_multi.sv
// srambank_multi: NBANKS x DEPTH x WIDTH single-port SRAM bank group with
// masked writes, read-valid strobe and sticky collision / out-of-range flags.
// Define SRAMBANK_OUTREG_EN for an extra output register (read latency 2).
module srambank_multi
   import srambank_pkg::*;
#(
   parameter  int WIDTH     = WIDTH_DEF,
   parameter  int DEPTH     = DEPTH_DEF,
   parameter  int NBANKS    = NBANKS_DEF,
   parameter  int MASK_GRAN = MASK_GRAN_DEF,
   localparam int AW        = clog2(NBANKS) + clog2(DEPTH),
   localparam int NS        = WIDTH / MASK_GRAN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    address,
   input  logic [WIDTH-1:0] wd,
   input  logic [NS-1:0]    wmask,
   input  logic             banksel,
   input  logic             read,
   input  logic             write,
   output logic [WIDTH-1:0] dataout,
   output logic             rvalid,
   output logic [1:0]       err,
   input  logic             err_clr
);

   localparam int RW  = clog2(DEPTH);
   localparam int BW  = clog2(NBANKS);
   localparam int BWS = (BW > 0) ? BW : 1;

   if ((WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
      $error("srambank_multi: WIDTH must be a multiple of MASK_GRAN");
   end

   logic [RW-1:0]    row;
   logic [BWS-1:0]   bank;
   logic             oor;
   logic             rd_req, acc_rd, acc_wr, coll, oor_err;
   logic [WIDTH-1:0] rdata [NBANKS];
   logic             v1, oor1;
   logic [BWS-1:0]   bank1;
   logic [WIDTH-1:0] dout1;
   logic [1:0]       err_nxt;

   assign row = address[RW-1:0];

   if (BW > 0) begin : g_bank_dec
      assign bank = address[AW-1:RW];
   end else begin : g_one_bank
      assign bank = '0;
   end

   // rows past DEPTH only exist when DEPTH is not a power of two
   if ((1 << RW) == DEPTH) begin : g_pow2
      assign oor = 1'b0;
   end else begin : g_npow2
      assign oor = (32'(row) >= DEPTH);
   end

   assign rd_req  = banksel & read & ~write;
   assign acc_rd  = rd_req & ~oor;
   assign acc_wr  = banksel & write & ~oor;
   assign coll    = banksel & read & write;
   assign oor_err = banksel & (read | write) & oor;

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      srambank_array #(
         .WIDTH     (WIDTH),
         .DEPTH     (DEPTH),
         .MASK_GRAN (MASK_GRAN),
         .RW        (RW),
         .NS        (NS)
      ) u_array (
         .clk   (clk),
         .reset (reset),
         .we    (acc_wr && (bank == BWS'(b))),
         .re    (acc_rd && (bank == BWS'(b))),
         .row   (row),
         .wd    (wd),
         .wmask (wmask),
         .rdata (rdata[b])
      );
   end

   // remember which bank (or out-of-range) the last completed read came from
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1    <= 1'b0;
         bank1 <= '0;
         oor1  <= 1'b0;
      end else begin
         v1 <= rd_req;
         if (rd_req) begin
            bank1 <= bank;
            oor1  <= oor;
         end
      end
   end

   assign dout1 = oor1 ? '0 : rdata[bank1];

`ifdef SRAMBANK_OUTREG_EN
   logic [WIDTH-1:0] dout2;
   logic             v2;

   // second output stage; data only moves with a valid so dataout still holds
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout2 <= '0;
         v2    <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) dout2 <= dout1;
      end
   end

   assign dataout = dout2;
   assign rvalid  = v2;
`else
   assign dataout = dout1;
   assign rvalid  = v1;
`endif

   // sticky flags: clear first, then a same-cycle new error re-sets its bit
   always_comb begin
      err_nxt = err_clr ? 2'b00 : err;
      if (coll)    err_nxt[ERR_COLL] = 1'b1;
      if (oor_err) err_nxt[ERR_OOR]  = 1'b1;
   end

   // error flag register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err <= 2'b00;
      else       err <= err_nxt;
   end

endmodule

// File: doc/srambank_multi.md
Name: srambank_multi

Overview:
Parametrised synchronous single-port SRAM bank group: NBANKS banks of DEPTH x WIDTH words, selected by the upper address bits.
- Adds per-segment write mask, a read-valid strobe, and sticky error flags for read+write collisions and out-of-range addresses.
- Optional second output pipeline stage.
- Drop-in successor for the fixed-size bank models in the generated SRAM library; sits between cache/tag controllers and the macro array.

Parameters:
WIDTH, 74, data word width in bits.
DEPTH, 64, words per bank; any value >= 2.
NBANKS, 4, bank count; power of two >= 1.
MASK_GRAN, 37, bits per write-mask segment; WIDTH % MASK_GRAN must be 0 (elaboration error otherwise).

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
address  in  ADDR_W  word address; ADDR_W = clog2(NBANKS) + clog2(DEPTH); upper clog2(NBANKS) bits = bank, lower bits = row.
wd  in  WIDTH  write data.
wmask  in  NSEG  per-segment write enable; NSEG = WIDTH/MASK_GRAN; 1 = write segment.
banksel  in  1  access enable; no access when 0.
read  in  1  read request.
write  in  1  write request.
dataout  out  WIDTH  latched read data; changes only on a completed read.
rvalid  out  1  one-cycle pulse aligned with updated dataout.
err  out  2  sticky flags: bit0 = read&write collision, bit1 = out-of-range row.
err_clr  in  1  synchronous clear of err.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - dataout = 0, rvalid = 0, err = 2'b00.
  - Pipeline stage(s) cleared; any in-flight read is discarded, so no rvalid after reset.
  - Memory contents are not reset.
- Access on an edge occurs only with banksel = 1.
- Write (write & banksel):
  - For each segment s with wmask[s] = 1, mem[bank][row][s] <= wd[s].
  - Other segments are retained. wmask = 0 writes nothing but is still a write cycle.
- Read (read & banksel & ~write):
  - Base latency 1: dataout <= mem[bank][row] and rvalid = 1 in the following cycle.
  - dataout holds until the next completed read, independent of intervening writes.
- Collision (read & write & banksel):
  - The write is performed; the read is dropped (no rvalid).
  - err[0] <= 1.
- Out-of-range (row >= DEPTH, possible only when DEPTH is not a power of two):
  - Write: ignored.
  - Read: completes with dataout = 0 and rvalid = 1.
  - Either case: err[1] <= 1.
- err handling:
  - err_clr clears both bits.
  - If a new error occurs in the same cycle as err_clr, the new error wins (its bit is set).
- Back-to-back reads sustain one per cycle. Write then read of the same address on the next cycle returns the new data.
- banksel = 0 with read/write high: no effect, no flags.

Optional Feature:
SRAMBANK_OUTREG_EN
- Defined: adds a second register stage after the array read. Read latency is 2; rvalid is delayed with the data. Reset clears both stages. Throughput is unchanged (one read per cycle).
- Undefined: latency 1 as above.

Decomposition:
- Package srambank_pkg:
  - clog2 function.
  - Derived constants ADDR_W, ROW_W, BANK_W, NSEG.
  - Error bit index constants ERR_COLL = 0 and ERR_OOR = 1.
- Sub-module srambank_array: one DEPTH x WIDTH masked-write, registered-read bank, instantiated NBANKS times by generate.
- Top level owns address decode, bank mux, rvalid/err logic and the optional output stage.

Test Plan:
- Reset check: assert reset mid-read (read issued, reset before edge) -> dataout = 0, rvalid = 0, err = 0; no stray rvalid after release.
- Basic read-back: write 74'h2_0000_0000_DEAD_BEEF to addr 8'hC5 with wmask = 2'b11, then read -> rvalid 1 cycle later (2 with SRAMBANK_OUTREG_EN), dataout = written value.
- Masked write:
  - Write all-ones to addr 3 with wmask = 2'b11.
  - Write 0 to addr 3 with wmask = 2'b01.
  - Read addr 3 -> upper 37 bits ones, lower 37 bits zero.
- Collision: read = write = banksel = 1 at addr 10 with wd = 5 -> no rvalid, err = 2'b01, later read of addr 10 = 5; err_clr -> err = 0.
- Out-of-range: DEPTH = 48 override, read of row 50 -> dataout = 0, rvalid = 1, err = 2'b10; write to row 50 leaves rows 0..47 unchanged.
- Bank isolation/streaming: write distinct values to row 0 of all 4 banks, then 4 back-to-back reads -> 4 consecutive rvalid pulses with matching data; dataout holds after an intervening write.
